// File: rtl/frame_feeder_pkg.sv
// Shared definitions for the image sample stream: FSM encoding and default image geometry.
// The state encoding is also used by the downstream sample gate.
package frame_feeder_pkg;

    localparam int IMG_DIM = 28;
    localparam int IMG_NUM = IMG_DIM * IMG_DIM;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feed_state_t;

endpackage

// File: rtl/feed_skid.sv
// Two-entry output buffer between the pixel memory and the stream output.
// The head entry drives the stream; a push while full is ignored unless a pop frees a slot.
module feed_skid #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 push,
    input  logic [BIT_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [1:0]           occ,
    output logic [BIT_WIDTH-1:0] head_data,
    output logic                 head_vld
);

    logic [BIT_WIDTH-1:0] head_p2;
    logic [BIT_WIDTH-1:0] tail_p2;
    logic [1:0]           occ_p2;
    logic                 do_pop;
    logic                 do_push;

    assign do_pop  = pop && (occ_p2 != 2'd0);
    assign do_push = push && ((occ_p2 != 2'd2) || do_pop);

    // Buffer stage: head/tail slots and occupancy
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            head_p2 <= '0;
            tail_p2 <= '0;
            occ_p2  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ_p2 == 2'd0) head_p2 <= push_data;
                    else                tail_p2 <= push_data;
                    occ_p2 <= occ_p2 + 2'd1;
                end
                2'b01: begin
                    head_p2 <= tail_p2;
                    tail_p2 <= '0;
                    occ_p2  <= occ_p2 - 2'd1;
                end
                2'b11: begin
                    if (occ_p2 == 2'd1) begin
                        head_p2 <= push_data;
                    end else begin
                        head_p2 <= tail_p2;
                        tail_p2 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ       = occ_p2;
    assign head_data = head_p2;
    assign head_vld  = (occ_p2 != 2'd0);

endmodule

// File: rtl/frame_feeder.sv
// Streams NUM samples of one image out of a synchronous-read pixel memory,
// honouring a downstream hold and flagging done once the last sample has transferred.
module frame_feeder
    import frame_feeder_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int NUM        = IMG_NUM,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic                  hold,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BIT_WIDTH-1:0]  mem_data,
    output logic [BIT_WIDTH-1:0]  out,
    output logic                  ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] NUM_W  = (ADDR_WIDTH+1)'(NUM);
    localparam logic [ADDR_WIDTH:0] LAST_W = (ADDR_WIDTH+1)'(NUM - 1);

    feed_state_t          state_q;
    feed_state_t          state_d;
    logic [ADDR_WIDTH:0]  rd_cnt;
    logic [ADDR_WIDTH:0]  sent_cnt;
    logic                 vld_p1;
    logic [1:0]           occ;
    logic [BIT_WIDTH-1:0] head_data;
    logic                 head_vld;
    logic                 xfer;
    logic [2:0]           pending;

    always_comb begin
        state_d  = state_q;
        busy     = (state_q == STREAM);
        done     = (state_q == DONE);
        ready    = busy && head_vld;
        out      = ready ? head_data : '0;
        xfer     = ready && !hold;
        // Slots already claimed once this cycle's transfer has left the buffer
        pending  = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, xfer};
        mem_en   = busy && (rd_cnt < NUM_W) && (pending < 3'd2);
        mem_addr = rd_cnt[ADDR_WIDTH-1:0];
        case (state_q)
            IDLE, DONE: if (start) state_d = STREAM;
            STREAM:     if (xfer && (sent_cnt == LAST_W)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Read stage: vld_p1 marks memory data arriving this cycle
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rd_cnt   <= '0;
            sent_cnt <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= mem_en;
            if ((state_q != STREAM) && start) begin
                rd_cnt   <= '0;
                sent_cnt <= '0;
            end else begin
                if (mem_en) rd_cnt   <= rd_cnt + 1'b1;
                if (xfer)   sent_cnt <= sent_cnt + 1'b1;
            end
        end
    end

    feed_skid #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_skid (
        .clk      (clk),
        .clr_n    (clr_n),
        .push     (vld_p1),
        .push_data(mem_data),
        .pop      (xfer),
        .occ      (occ),
        .head_data(head_data),
        .head_vld (head_vld)
    );

endmodule

// File: tb/tb_frame_feeder.sv
// Bench for frame_feeder: NUM=8 instance for streaming/stall/reset/random cases,
// NUM=1 instance for the single-sample boundary.
module tb_frame_feeder;

    localparam int BW  = 32;
    localparam int N8  = 8;
    localparam int AW8 = 3;
    localparam int N1  = 1;
    localparam int AW1 = 2;
    localparam int BUDGET = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           a_clr_n, a_start, a_hold, a_mem_en, a_ready, a_busy, a_done;
    logic [AW8-1:0] a_mem_addr;
    logic [BW-1:0]  a_mem_data, a_out;
    logic [BW-1:0]  a_mem [0:N8-1];

    logic           b_clr_n, b_start, b_hold, b_mem_en, b_ready, b_busy, b_done;
    logic [AW1-1:0] b_mem_addr;
    logic [BW-1:0]  b_mem_data, b_out;
    logic [BW-1:0]  b_mem [0:3];

    frame_feeder #(.BIT_WIDTH(BW), .NUM(N8), .ADDR_WIDTH(AW8)) dut_a (
        .clk(clk), .clr_n(a_clr_n), .start(a_start), .hold(a_hold),
        .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
        .out(a_out), .ready(a_ready), .busy(a_busy), .done(a_done)
    );

    frame_feeder #(.BIT_WIDTH(BW), .NUM(N1), .ADDR_WIDTH(AW1)) dut_b (
        .clk(clk), .clr_n(b_clr_n), .start(b_start), .hold(b_hold),
        .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
        .out(b_out), .ready(b_ready), .busy(b_busy), .done(b_done)
    );

    // Synchronous-read pixel memories
    always @(posedge clk) begin
        if (a_mem_en) a_mem_data <= a_mem[a_mem_addr];
        if (b_mem_en) b_mem_data <= b_mem[b_mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit hold_pat  [0:BUDGET-1];
    bit start_pat [0:BUDGET-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pats();
        for (int i = 0; i < BUDGET; i++) begin
            hold_pat[i]  = 1'b0;
            start_pat[i] = 1'b0;
        end
    endtask

    // One stream on dut_a, start in relative cycle 0. Expected behaviour: samples M[0..7] in
    // order, one per cycle from cycle 3 except on held cycles, done the cycle after the last transfer.
    task automatic run8(input string tag);
        int          idx;
        int          stalls;
        int          hits [0:N8-1];
        bit          finished;
        bit          prev_stall;
        logic [31:0] prev_out;
        idx = 0; stalls = 0; finished = 1'b0; prev_stall = 1'b0; prev_out = '0;
        for (int i = 0; i < N8; i++) hits[i] = 0;
        for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            a_start = (cyc == 0) || (start_pat[cyc] && idx < N8);
            a_hold  = hold_pat[cyc];
            @(negedge clk);
            if (a_mem_en) hits[int'(a_mem_addr)]++;
            if (cyc == 1) begin
                check_eq({tag, " first mem_en"}, 32'(a_mem_en), 1);
                check_eq({tag, " first mem_addr"}, 32'(a_mem_addr), 0);
            end
            if (cyc == 2) check_eq({tag, " ready before data"}, 32'(a_ready), 0);
            if (idx == N8) begin
                check_eq({tag, " done"}, 32'(a_done), 1);
                check_eq({tag, " ready at done"}, 32'(a_ready), 0);
                check_eq({tag, " out at done"}, a_out, 0);
                check_eq({tag, " busy at done"}, 32'(a_busy), 0);
                check_eq({tag, " done cycle"}, cyc, 3 + N8 + stalls);
                finished = 1'b1;
            end else if (cyc >= 1) begin
                check_eq({tag, " done early"}, 32'(a_done), 0);
                check_eq({tag, " busy"}, 32'(a_busy), 1);
                if (cyc >= 3) begin
                    check_eq({tag, " ready"}, 32'(a_ready), 1);
                    check_eq({tag, " out"}, a_out, a_mem[idx]);
                    if (prev_stall) check_eq({tag, " held out stable"}, a_out, prev_out);
                    prev_stall = a_hold;
                    prev_out   = a_out;
                    if (a_hold) stalls++;
                    else        idx++;
                end
            end
            next_cycle();
        end
        if (!finished) check_eq({tag, " timeout"}, 0, 1);
        for (int i = 0; i < N8; i++) check_eq({tag, " addr read once"}, hits[i], 1);
        a_start = 1'b0;
        a_hold  = 1'b0;
        clear_pats();
    endtask

    initial begin
        int pulses;
        a_clr_n = 1'b0; a_start = 1'b0; a_hold = 1'b0;
        b_clr_n = 1'b0; b_start = 1'b0; b_hold = 1'b0;
        for (int i = 0; i < N8; i++) a_mem[i] = 32'(i + 1);
        for (int i = 0; i < 4; i++)  b_mem[i] = 32'h0;
        b_mem[0] = 32'hDEADBEEF;
        clear_pats();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("reset out", a_out, 0);
        check_eq("reset ready", 32'(a_ready), 0);
        check_eq("reset busy", 32'(a_busy), 0);
        check_eq("reset done", 32'(a_done), 0);
        check_eq("reset mem_en", 32'(a_mem_en), 0);
        check_eq("reset mem_addr", 32'(a_mem_addr), 0);
        a_clr_n = 1'b1;
        b_clr_n = 1'b1;
        next_cycle();

        run8("basic");

        // hold and idle cycles in DONE change nothing
        for (int c = 0; c < 3; c++) begin
            a_hold = 1'(c % 2);
            @(negedge clk);
            check_eq("done sticky", 32'(a_done), 1);
            check_eq("done no read", 32'(a_mem_en), 0);
            next_cycle();
        end
        a_hold = 1'b0;
        run8("restart");

        hold_pat[4] = 1'b1; hold_pat[5] = 1'b1; hold_pat[6] = 1'b1;
        hold_pat[7] = 1'b1; hold_pat[9] = 1'b1;
        run8("stall");

        start_pat[5] = 1'b1;
        run8("busy_start");

        // reset mid-stream with reads in flight
        a_start = 1'b1;
        next_cycle();
        a_start = 1'b0;
        repeat (5) next_cycle();
        a_clr_n = 1'b0;
        next_cycle();
        a_clr_n = 1'b1;
        @(negedge clk);
        check_eq("midrst out", a_out, 0);
        check_eq("midrst ready", 32'(a_ready), 0);
        check_eq("midrst busy", 32'(a_busy), 0);
        check_eq("midrst done", 32'(a_done), 0);
        check_eq("midrst mem_en", 32'(a_mem_en), 0);
        check_eq("midrst mem_addr", 32'(a_mem_addr), 0);
        next_cycle();
        run8("after_reset");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N8; i++) a_mem[i] = $urandom;
            for (int i = 1; i < BUDGET; i++) begin
                hold_pat[i]  = ($urandom_range(0, 2) == 0);
                start_pat[i] = ($urandom_range(0, 9) == 0);
            end
            run8("random");
        end

        // single-sample image
        pulses = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            b_start = (cyc == 0);
            b_hold  = 1'b0;
            @(negedge clk);
            if (b_mem_en) pulses++;
            if (cyc == 1) begin
                check_eq("n1 mem_en", 32'(b_mem_en), 1);
                check_eq("n1 mem_addr", 32'(b_mem_addr), 0);
            end
            if (cyc == 3) begin
                check_eq("n1 out", b_out, 32'hDEADBEEF);
                check_eq("n1 ready", 32'(b_ready), 1);
            end
            if (cyc == 4) begin
                check_eq("n1 done", 32'(b_done), 1);
                check_eq("n1 ready at done", 32'(b_ready), 0);
            end
            next_cycle();
        end
        b_start = 1'b0;
        check_eq("n1 read count", pulses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
